// File: rtl/bill_acceptor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bill_acceptor_pkg
//  Description : Shared definitions for the bill acceptor. Holds the raw
//                denomination codes, the sampler state type and the escrow
//                entry encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bill_acceptor_pkg;

    // Raw denomination codes reported by the slot sensor
    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TEN     = 2'b01;
    localparam logic [1:0] CODE_TWENTY  = 2'b10;
    localparam logic [1:0] CODE_INVALID = 2'b11;

    // Escrow entry encoding (one bit per queued bill)
    localparam logic ENTRY_TEN    = 1'b0;
    localparam logic ENTRY_TWENTY = 1'b1;

    // Sampler state machine
    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_DEBOUNCE    = 2'd1,
        S_CAPTURE     = 2'd2,
        S_WAIT_REMOVE = 2'd3
    } sampler_state_t;

    // True for the two codes that carry credit
    function automatic logic code_is_credit(input logic [1:0] code);
        return (code == CODE_TEN) || (code == CODE_TWENTY);
    endfunction

endpackage : bill_acceptor_pkg
`default_nettype wire

// File: rtl/bill_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bill_fifo
//  Description : Escrow queue of accepted bills. One-bit entries, synchronous
//                clear, exact occupancy count across pointer wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module bill_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       i_push,
    input  logic       i_din,
    input  logic       i_pop,
    output logic       o_dout,
    output logic       o_full,
    output logic       o_empty,
    output logic [4:0] o_level
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [4:0]          r_count;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally at their full width
    always_ff @(posedge clk) begin
        if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else begin
            if (i_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: clearing the pointers discards the contents
    always_ff @(posedge clk) begin
        if (!clear && i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == 5'(DEPTH));
    assign o_empty = (r_count == 5'd0);
    assign o_level = r_count;

endmodule : bill_fifo
`default_nettype wire

// File: rtl/bill_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : bill_acceptor
//  Description : Debounces the bill slot sensor, captures one denomination
//                per physical insertion into an escrow queue (or rejects it),
//                and issues ten/twenty credit pulses to the ticket machine.
//                Optional macro BILL_ACCEPTOR_STATS_EN adds a saturating
//                credit_total counter in units of 10.
//  Revision    : 1.0 - initial release
// ============================================================================
module bill_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        bill_present,
    input  logic [1:0]  bill_code,
    input  logic        ready_in,
    input  logic        bill_in,
    output logic        ten,
    output logic        twenty,
    output logic        reject,
    output logic        full,
`ifdef BILL_ACCEPTOR_STATS_EN
    output logic [15:0] credit_total,
`endif
    output logic [4:0]  level
);

    import bill_acceptor_pkg::*;

    localparam logic [3:0] c_DEB_TARGET = 4'(DEBOUNCE_CYCLES);

    sampler_state_t r_state;
    sampler_state_t w_state_next;
    logic [1:0]     r_code;
    logic [1:0]     w_code_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    logic           w_push;
    logic           w_push_data;
    logic           w_reject_next;

    logic           w_pop;
    logic           w_head;
    logic           w_full;
    logic           w_empty;
    logic [4:0]     w_level;

    logic           r_ten;
    logic           r_twenty;
    logic           r_reject;

    // Sampler state register; clear parks the FSM until the slot is empty
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_WAIT_REMOVE;
            r_code  <= CODE_NONE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Sampler next-state, debounce counter and capture decisions
    always_comb begin
        w_state_next  = r_state;
        w_code_next   = r_code;
        w_cnt_next    = r_cnt;
        w_push        = 1'b0;
        w_push_data   = ENTRY_TEN;
        w_reject_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bill_present) begin
                    w_state_next = S_DEBOUNCE;
                    w_code_next  = bill_code;
                    w_cnt_next   = 4'd1;
                end
            end
            S_DEBOUNCE: begin
                // Once the required stable run is proven, capture regardless
                // of what the sensor does in this cycle
                if (r_cnt == c_DEB_TARGET) begin
                    w_state_next = S_CAPTURE;
                end else if (!bill_present) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (bill_code != r_code) begin
                    w_code_next  = bill_code;
                    w_cnt_next   = 4'd1;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            S_CAPTURE: begin
                if (code_is_credit(r_code) && !w_full) begin
                    w_push      = 1'b1;
                    w_push_data = (r_code == CODE_TWENTY) ? ENTRY_TWENTY : ENTRY_TEN;
                end else begin
                    w_reject_next = 1'b1;
                end
                w_state_next = S_WAIT_REMOVE;
                w_cnt_next   = 4'd0;
            end
            S_WAIT_REMOVE: begin
                if (!bill_present) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // A pulse currently on the outputs blocks the next pop, which guarantees
    // an idle cycle between consecutive credit pulses
    assign w_pop = !w_empty && (ready_in || bill_in) && !(r_ten || r_twenty);

    bill_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clear   (clear),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Registered one-cycle output pulses
    always_ff @(posedge clk) begin
        if (clear) begin
            r_ten    <= 1'b0;
            r_twenty <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_ten    <= w_pop && (w_head == ENTRY_TEN);
            r_twenty <= w_pop && (w_head == ENTRY_TWENTY);
            r_reject <= w_reject_next;
        end
    end

`ifdef BILL_ACCEPTOR_STATS_EN
    logic [15:0] r_credit;
    logic [16:0] w_credit_sum;

    assign w_credit_sum = {1'b0, r_credit} + ((w_head == ENTRY_TWENTY) ? 17'd2 : 17'd1);

    // Saturating total of issued credit, counted when the head is popped
    always_ff @(posedge clk) begin
        if (clear) begin
            r_credit <= 16'd0;
        end else if (w_pop) begin
            r_credit <= w_credit_sum[16] ? 16'hFFFF : w_credit_sum[15:0];
        end
    end

    assign credit_total = r_credit;
`endif

    assign ten    = r_ten;
    assign twenty = r_twenty;
    assign reject = r_reject;
    assign full   = w_full;
    assign level  = w_level;

endmodule : bill_acceptor
`default_nettype wire

// File: doc/bill_acceptor.md
BILL_ACCEPTOR -- requirements
Module: bill_acceptor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive stable cycles needed to accept a bill (legal range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving escrow queue entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port clear, input, 1, synchronous active-high reset.
REQ-005 SHALL have port bill_present, input, 1, raw slot sensor.
REQ-006 SHALL have port bill_code, input, 2, raw denomination: 00 none, 01 ten, 10 twenty, 11 invalid.
REQ-007 SHALL have port ready_in, input, 1, downstream ticket-machine idle indication.
REQ-008 SHALL have port bill_in, input, 1, downstream ticket-machine collecting-money indication.
REQ-009 SHALL have port ten, output, 1, registered one-cycle credit pulse of 10.
REQ-010 SHALL have port twenty, output, 1, registered one-cycle credit pulse of 20.
REQ-011 SHALL have port reject, output, 1, registered one-cycle pulse that ejects the current bill.
REQ-012 SHALL have port full, output, 1, asserted when the escrow queue holds FIFO_DEPTH entries.
REQ-013 SHALL have port level, output, 5, current escrow occupancy 0..FIFO_DEPTH.

Function
REQ-014 Sampler FSM states SHALL be IDLE, DEBOUNCE, CAPTURE, WAIT_REMOVE.
REQ-015 IDLE SHALL go to DEBOUNCE when bill_present=1, latching bill_code and loading the stability counter to 1.
REQ-016 DEBOUNCE SHALL increment the counter while bill_present=1 and bill_code equals the latched code, restart at 1 with the new code on a code change, and return to IDLE with no effect when bill_present=0.
REQ-017 DEBOUNCE SHALL go to CAPTURE in the cycle after the counter reaches DEBOUNCE_CYCLES.
REQ-018 CAPTURE SHALL last exactly one cycle: a latched code of 01/10 with queue not full SHALL push; code 00/11, or a full queue, SHALL pulse reject for one cycle instead; then go to WAIT_REMOVE.
REQ-019 WAIT_REMOVE SHALL go to IDLE in the cycle after bill_present=0, so one physical insertion yields at most one push or reject.
REQ-020 Escrow queue SHALL be FIFO-ordered; entry width 1 bit (0 = ten, 1 = twenty).
REQ-021 Issue rule: when the queue is non-empty, (ready_in|bill_in)=1 and no pulse was issued in the previous cycle, the head SHALL be popped and the matching ten or twenty SHALL be high in the next cycle.
REQ-022 ten and twenty SHALL never be high together, and at least one idle cycle SHALL separate consecutive pulses.
REQ-023 A push and a pop in the same cycle SHALL leave level unchanged; push into full is impossible per REQ-018; pop from empty SHALL not occur.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be exact across wrap.

Reset
REQ-025 On clear=1 at a rising edge: queue emptied, level=0, full=0, ten=0, twenty=0, reject=0, counter=0, FSM=WAIT_REMOVE; clear SHALL override every other event in that cycle.
REQ-026 A bill present during or mid-debounce at clear SHALL be neither credited nor rejected; the FSM SHALL wait for its removal.
REQ-027 Queued bills not yet issued at clear SHALL be discarded.

Configuration
REQ-028 Macro BILL_ACCEPTOR_STATS_EN SHALL, when defined, add output credit_total (16 bits), counting issued value in units of 10 (ten +1, twenty +2), saturating at 16'hFFFF and zeroed by clear.
REQ-029 Without BILL_ACCEPTOR_STATS_EN the credit_total port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package bill_acceptor_pkg SHALL hold the bill_code constants (CODE_NONE, CODE_TEN, CODE_TWENTY, CODE_INVALID), the sampler state type, and the entry encoding.
REQ-031 The escrow queue SHALL be a sub-module named bill_fifo (synchronous, clear-reset, push/pop/full/empty/level).

Verification
REQ-032 bill_present=1, code=01 held 4 cycles, ready_in=1 -> one push; ten pulses for exactly one cycle; level returns to 0.
REQ-033 code toggling 01/10 every 2 cycles for 10 cycles, then 10 held 4 cycles -> exactly one push, entry twenty; no reject.
REQ-034 ready_in=bill_in=0, insert 5 valid bills -> level=4, full=1, fifth insertion gives one reject pulse; then bill_in=1 -> 4 pulses in insertion order, each separated by at least one idle cycle.
REQ-035 code=11 held 4 cycles -> reject single pulse, level unchanged, no ten/twenty.
REQ-036 clear asserted at debounce count 2 with bill held -> no push/reject until bill_present=0; outputs all 0 the cycle after clear.
REQ-037 With BILL_ACCEPTOR_STATS_EN, issue 3 ten and 2 twenty -> credit_total=7; preload to 16'hFFFE, issue twenty -> 16'hFFFF.
